mem_stage: RTL

Memory-access pipeline stage of the in-order RV64 core. It sits between the execute/memory pipeline register (input `execute_data_t`) and the memory/writeback register (output `memory_data_t`).
- Issues one data-bus transaction per load or store, holding it until the bus signals completion.
- Aligns store data and byte strobes; extracts and extends load data.
- Stalls upstream while a transaction is outstanding.

---
 rtl/mem_stage_if.sv | 63 ++++++
 rtl/mem_stage.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// Shared pipeline types for the memory stage and the data-bus interface it drives.
// The bus carries one request at a time; dresp_data_ok closes it.
package mem_pkg;
   typedef enum logic [1:0] {MSIZE1 = 2'd0, MSIZE2 = 2'd1, MSIZE4 = 2'd2, MSIZE8 = 2'd3} msize_t;

   typedef struct packed {
      logic   regwrite;
      logic   memread;
      logic   memwrite;
      msize_t memsize;
      logic   zeroextwb;
   } control_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] pc;
      logic [31:0] raw_instr;
      control_t    ctl;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic [4:0]  dst;
      logic [11:0] csraddr;
      logic [63:0] csrdata;
      logic [63:0] aluout;
      logic [63:0] memwd;
   } execute_data_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] pc;
      logic [31:0] raw_instr;
      control_t    ctl;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic [4:0]  dst;
      logic [11:0] csraddr;
      logic [63:0] csrdata;
      logic [63:0] writedata;
      logic [63:0] memaddr;
   } memory_data_t;
endpackage

interface mem_stage_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) ();
   logic                  dreq_valid;
   logic [ADDR_W-1:0]     dreq_addr;
   mem_pkg::msize_t       dreq_size;
   logic [DATA_W/8-1:0]   dreq_strobe;
   logic [DATA_W-1:0]     dreq_data;
   logic                  dresp_data_ok;
   logic [DATA_W-1:0]     dresp_data;

   modport master (
      output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
      input  dresp_data_ok, dresp_data
   );
   modport slave (
      input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
      output dresp_data_ok, dresp_data
   );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: one bus transaction per load/store, store lane alignment,
// load extraction/extension, and upstream stall while a transaction is open.
module mem_lane #(
   parameter int NUM_LANES = 8,
   parameter int OFF_W     = 3,
   parameter int LANE      = 0
) (
   input  logic [OFF_W-1:0]          off,
   input  logic [OFF_W:0]            nbytes,
   input  logic [NUM_LANES-1:0][7:0] wd,
   output logic                      strb,
   output logic [7:0]                lane_data
);
   localparam logic [OFF_W:0] LANE_IDX = LANE[OFF_W:0];

   logic [OFF_W:0] rel;
   logic           in_rng;

   // Lane LANE carries source byte LANE-off; lanes below the offset shift in zeros.
   always_comb begin
      rel       = LANE_IDX - {1'b0, off};
      in_rng    = ({1'b0, off} <= LANE_IDX);
      strb      = in_rng && (rel < nbytes);
      lane_data = in_rng ? wd[rel[OFF_W-1:0]] : 8'h00;
   end
endmodule

module mem_stage
   import mem_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  execute_data_t in_data,
   output logic          mem_stall,
   output memory_data_t  out_data,
   mem_stage_if.master   dbus
);
   localparam int NUM_LANES = DATA_W / 8;
   localparam int OFF_W     = $clog2(NUM_LANES);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t       state;
   memory_data_t lat_m;
   memory_data_t pend;

   logic                      accept, is_mem, done;
   logic [OFF_W-1:0]          req_off;
   logic [OFF_W:0]            req_nbytes;
   logic [NUM_LANES-1:0][7:0] wd, st_data;
   logic [NUM_LANES-1:0]      st_strb;
   logic [DATA_W-1:0]         ld_raw;
   logic [63:0]               ld_val;
   memory_data_t              cmpl;

   function automatic memory_data_t pass_through(execute_data_t d, logic [63:0] wdata);
      memory_data_t m;
      m.valid     = 1'b1;
      m.pc        = d.pc;
      m.raw_instr = d.raw_instr;
      m.ctl       = d.ctl;
      m.ra1       = d.ra1;
      m.ra2       = d.ra2;
      m.dst       = d.dst;
      m.csraddr   = d.csraddr;
      m.csrdata   = d.csrdata;
      m.writedata = wdata;
      m.memaddr   = d.aluout;
      return m;
   endfunction

   assign done      = (state == BUSY) && dbus.dresp_data_ok;
   assign mem_stall = (state == BUSY) && !dbus.dresp_data_ok;
   assign accept    = in_data.valid && !mem_stall;
   assign is_mem    = in_data.ctl.memread || in_data.ctl.memwrite;
   assign req_off   = in_data.aluout[OFF_W-1:0];
   assign wd        = DATA_W'(in_data.memwd);

   always_comb begin
      case (in_data.ctl.memsize)
         MSIZE1:  req_nbytes = (OFF_W+1)'(1);
         MSIZE2:  req_nbytes = (OFF_W+1)'(2);
         MSIZE4:  req_nbytes = (OFF_W+1)'(4);
         default: req_nbytes = (OFF_W+1)'(8);
      endcase
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      mem_lane #(.NUM_LANES(NUM_LANES), .OFF_W(OFF_W), .LANE(i)) u_lane (
         .off       (req_off),
         .nbytes    (req_nbytes),
         .wd        (wd),
         .strb      (st_strb[i]),
         .lane_data (st_data[i])
      );
   end

   always_comb begin
      ld_raw = dbus.dresp_data >> {lat_m.memaddr[OFF_W-1:0], 3'b000};
      case (lat_m.ctl.memsize)
         MSIZE1:  ld_val = lat_m.ctl.zeroextwb ? 64'(ld_raw[7:0])  : {{56{ld_raw[7]}},  ld_raw[7:0]};
         MSIZE2:  ld_val = lat_m.ctl.zeroextwb ? 64'(ld_raw[15:0]) : {{48{ld_raw[15]}}, ld_raw[15:0]};
         MSIZE4:  ld_val = lat_m.ctl.zeroextwb ? 64'(ld_raw[31:0]) : {{32{ld_raw[31]}}, ld_raw[31:0]};
         default: ld_val = 64'(ld_raw);
      endcase
      cmpl           = lat_m;
      cmpl.valid     = 1'b1;
      cmpl.writedata = lat_m.ctl.memread ? ld_val : 64'd0;
   end

   // A non-memory op accepted on a completion edge cannot share out_data with the
   // finishing load/store, so it waits one edge in pend; pend drains on the next edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         lat_m            <= '0;
         pend             <= '0;
         out_data         <= '0;
         dbus.dreq_valid  <= 1'b0;
         dbus.dreq_addr   <= '0;
         dbus.dreq_size   <= MSIZE1;
         dbus.dreq_strobe <= '0;
         dbus.dreq_data   <= '0;
      end else begin
         if (pend.valid) out_data <= pend;
         else            out_data.valid <= 1'b0;
         pend.valid <= 1'b0;

         if (done) begin
            out_data        <= cmpl;
            state           <= IDLE;
            dbus.dreq_valid <= 1'b0;
         end

         if (accept) begin
            if (is_mem) begin
               state            <= BUSY;
               lat_m            <= pass_through(in_data, 64'd0);
               dbus.dreq_valid  <= 1'b1;
               dbus.dreq_addr   <= ADDR_W'(in_data.aluout);
               dbus.dreq_size   <= in_data.ctl.memsize;
               dbus.dreq_strobe <= in_data.ctl.memwrite ? st_strb : '0;
               dbus.dreq_data   <= st_data;
            end else if (done || pend.valid) begin
               pend <= pass_through(in_data, in_data.aluout);
            end else begin
               out_data <= pass_through(in_data, in_data.aluout);
            end
         end
      end
   end
endmodule
